unidade_busca: RTL and testbench
================================

// Module: unidade_busca
// PURPOSE
//  Instruction-fetch stage of the Redux-V core. Sits directly upstream of the instruction memory:
//  drives its 8-bit read address, captures the combinational 8-bit instruction it returns and
//  queues {pc, instruction} pairs toward the decoder over a valid/ready handshake.
//  Owns the program counter and handles sequential increment, stall and branch/jump redirect.
// PARAMETERS
//  ADDR_W    8     PC / instruction-memory address width
//  INSTR_W   8     instruction width
//  RESET_PC  8'h00 PC value loaded on reset
//  BUF_DEPTH 2     fetch-queue entries (power of 2, >=2)
// PORTS
//  clk          in   1        single clock, all state updates on rising edge
//  rst          in   1        synchronous, active-high reset
//  habilita     in   1        fetch enable; 0 = no new fetches, queue still drains
//  desvio       in   1        redirect request (taken branch/jump), single-cycle pulse
//  alvo         in   ADDR_W   redirect target, sampled when desvio=1
//  endereco     out  ADDR_W   address to instruction memory (= current PC, combinational)
//  instrucao    in   INSTR_W  instruction from memory, combinational read of endereco
//  instr_saida  out  INSTR_W  head-of-queue instruction to decoder
//  pc_saida     out  ADDR_W   address the head instruction was fetched from
//  valido       out  1        head entry valid
//  pronto       in   1        decoder accepts head entry this cycle
// BEHAVIOUR
//  - Reset (priority over all): PC<=RESET_PC, queue emptied; next cycle valido=0,
//    endereco=RESET_PC; instr_saida/pc_saida=0 while empty. desvio ignored while rst=1.
//  - push = habilita & !cheio & !desvio: writes {pc, instrucao} to tail, PC<=PC+1.
//  - PC arithmetic modulo 2^ADDR_W: 8'hFF+1 -> 8'h00, no flag.
//  - pop = valido & pronto: head advances. pronto with valido=0 is ignored.
//  - Latency: instruction at address A is visible on instr_saida/valido the cycle after A
//    is on endereco (queue empty, push that cycle). Throughput 1 instr/cycle with pronto=1.
//  - Push and pop in the same cycle: both occur, count unchanged. cheio/vazio are registered
//    state: no push when full even if pop same cycle (no bypass); no pop-through when empty.
//  - Full: PC and endereco hold; memory re-read of same address is harmless.
//  - Redirect (desvio=1): PC<=alvo, queue flushed (all entries dropped, including any head
//    popped the same cycle -- decoder must discard it); no push that cycle.
//    Next cycle: valido=0, endereco=alvo; first redirected instr valid the cycle after.
//  - habilita=0: PC holds, no push; desvio still honoured.
//  - Order strictly FIFO; pc_saida always matches instr_saida of the same entry.
//  - No X on outputs after first reset cycle.
// STRUCTURE
//  - Shared package redux_v_pkg: ADDR_W, INSTR_W, RESET_PC constants and typedef
//    entrada_busca_t = struct {pc, instr} used by this block and the decoder.
//  - Sub-module fila_busca: generic synchronous FIFO (BUF_DEPTH, entry type) with
//    push/pop/flush, cheio/vazio, head read registered-state only. Top keeps PC logic.
// TESTING (bench memory model: combinational, mem[a]=a^8'h55 unless stated)
//  1 Reset 2 cycles, habilita=1, pronto=1 -> cycle 1 after reset: valido=1, pc_saida=00,
//    instr=55; then 01/54, 02/57 on consecutive cycles.
//  2 pronto=0 from reset for 5 cycles -> endereco stops at 02, queue holds 00,01;
//    raise pronto -> pc_saida 00,01,02,03 in order, no gaps or duplicates.
//  3 Queue full (00,01), desvio=1 alvo=80 -> next cycle valido=0, endereco=80;
//    following cycle valido=1, pc_saida=80, instr=D5.
//  4 RESET_PC=FE, mem[FF]=FF -> pc_saida FE, FF (instr FF), 00 (instr 55); wrap clean.
//  5 rst=1 mid-stream with queue full and desvio=1 same cycle -> next cycle valido=0,
//    endereco=RESET_PC; desvio target ignored.
//  6 habilita=0 with 2 queued, pronto=1 -> both drain, then valido=0, endereco constant;
//    habilita=1 resumes at held PC.

Source files
------------

// File: rtl/redux_v_pkg.sv
// Shared Redux-V front-end types: fetch address/instruction widths and the {pc, instr} entry
// passed from the fetch stage to the decoder.
package redux_v_pkg;

  localparam int ADDR_W = 8;
  localparam int INSTR_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entrada_busca_t;

endpackage

// File: rtl/unidade_busca_fila.sv
// Generic synchronous FIFO with flush; head is read from registered state only, so there is
// no write-through when empty and no push accepted when full even if a pop happens that cycle.
module fila_busca #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  T     i_dat,
  output T     o_dat,
  output logic o_cheio,
  output logic o_vazio
);

  localparam int PW = $clog2(DEPTH);

  T             r_mem [DEPTH];
  logic [PW:0]  r_wr_ptr;
  logic [PW:0]  r_rd_ptr;
  logic         w_push;
  logic         w_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign o_vazio = (r_wr_ptr == r_rd_ptr);
  assign o_cheio = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = i_push & ~o_cheio;
  assign w_pop   = i_pop & ~o_vazio;

  always_comb begin
    o_dat = '0;
    if (!o_vazio) o_dat = r_mem[r_rd_ptr[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[PW-1:0]] <= i_dat;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Redux-V fetch stage: owns the PC, reads instruction memory combinationally and queues
// {pc, instr} toward the decoder; one-cycle fetch latency, stalls PC when the queue is full.
module unidade_busca #(
  parameter int                ADDR_W    = redux_v_pkg::ADDR_W,
  parameter int                INSTR_W   = redux_v_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = redux_v_pkg::RESET_PC,
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               habilita,
  input  logic               desvio,
  input  logic [ADDR_W-1:0]  alvo,
  output logic [ADDR_W-1:0]  endereco,
  input  logic [INSTR_W-1:0] instrucao,
  output logic [INSTR_W-1:0] instr_saida,
  output logic [ADDR_W-1:0]  pc_saida,
  output logic               valido,
  input  logic               pronto
);

  import redux_v_pkg::*;

  logic [ADDR_W-1:0] r_pc;
  logic              w_push;
  logic              w_cheio;
  logic              w_vazio;
  entrada_busca_t    w_entrada;
  entrada_busca_t    w_cabeca;

  // A redirect wins over fetching: the instruction read at the old PC is on the wrong path.
  assign w_push          = habilita & ~w_cheio & ~desvio;
  assign w_entrada.pc    = r_pc;
  assign w_entrada.instr = instrucao;

  assign endereco    = r_pc;
  assign valido      = ~w_vazio;
  assign pc_saida    = w_cabeca.pc;
  assign instr_saida = w_cabeca.instr;

  always_ff @(posedge clk) begin
    if (rst)         r_pc <= RESET_PC;
    else if (desvio) r_pc <= alvo;
    else if (w_push) r_pc <= r_pc + 1'b1;
  end

  fila_busca #(
    .DEPTH (BUF_DEPTH),
    .T     (entrada_busca_t)
  ) u_fila (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (pronto),
    .i_flush (desvio),
    .i_dat   (w_entrada),
    .o_dat   (w_cabeca),
    .o_cheio (w_cheio),
    .o_vazio (w_vazio)
  );

endmodule

// File: tb/tb_unidade_busca.sv
// Two fetch units (RESET_PC 00 and FE) driven in lockstep against a queue-based reference model.
module tb_unidade_busca;

  import redux_v_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [7:0] RST_PC [2] = '{8'h00, 8'hFE};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       habilita = 1'b1;
  logic       desvio = 1'b0;
  logic [7:0] alvo = 8'h00;
  logic       pronto = 1'b1;

  logic [7:0] end0, ins0, isai0, pcs0;
  logic [7:0] end1, ins1, isai1, pcs1;
  logic       val0, val1;

  int n_checks = 0;
  int n_errors = 0;

  entrada_busca_t m_q [2][$];
  logic [7:0]     m_pc [2];
  bit             m_live = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(int k, logic [7:0] a);
    if (k == 1 && a == 8'hFF) return 8'hFF;
    return a ^ 8'h55;
  endfunction

  assign ins0 = mem_rd(0, end0);
  assign ins1 = mem_rd(1, end1);

  unidade_busca #(.RESET_PC(8'h00), .BUF_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rst(rst), .habilita(habilita), .desvio(desvio), .alvo(alvo),
    .endereco(end0), .instrucao(ins0), .instr_saida(isai0), .pc_saida(pcs0),
    .valido(val0), .pronto(pronto)
  );

  unidade_busca #(.RESET_PC(8'hFE), .BUF_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .habilita(habilita), .desvio(desvio), .alvo(alvo),
    .endereco(end1), .instrucao(ins1), .instr_saida(isai1), .pc_saida(pcs1),
    .valido(val1), .pronto(pronto)
  );

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the fetch queue as a plain list, updated with the architectural rules.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_q[k].delete();
        m_pc[k] = RST_PC[k];
      end else if (desvio) begin
        m_q[k].delete();
        m_pc[k] = alvo;
      end else begin
        int n;
        n = m_q[k].size();
        if (pronto && n > 0) void'(m_q[k].pop_front());
        if (habilita && n < DEPTH) begin
          m_q[k].push_back('{pc: m_pc[k], instr: mem_rd(k, m_pc[k])});
          m_pc[k] = m_pc[k] + 8'd1;
        end
      end
    end
    if (rst) m_live = 1;
  end

  task automatic mon(int k, logic v, logic [7:0] e, logic [7:0] p, logic [7:0] i);
    chk($sformatf("nox%0d", k), {7'b0, $isunknown({v, e, p, i})}, 8'h00);
    chk($sformatf("valido%0d", k), {7'b0, v}, {7'b0, (m_q[k].size() != 0)});
    chk($sformatf("endereco%0d", k), e, m_pc[k]);
    if (m_q[k].size() != 0) begin
      chk($sformatf("pc_saida%0d", k), p, m_q[k][0].pc);
      chk($sformatf("instr_saida%0d", k), i, m_q[k][0].instr);
    end else begin
      chk($sformatf("pc_idle%0d", k), p, 8'h00);
      chk($sformatf("instr_idle%0d", k), i, 8'h00);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      mon(0, val0, end0, pcs0, isai0);
      mon(1, val1, end1, pcs1, isai1);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset, then free-running fetch with the decoder always ready.
    cyc(2);
    rst = 1'b0;
    chk("rst_valido", {7'b0, val0}, 8'h00);
    chk("rst_end0", end0, 8'h00);
    chk("rst_end1", end1, 8'hFE);
    cyc(1);
    chk("f1_pc", pcs0, 8'h00); chk("f1_ins", isai0, 8'h55); chk("f1_val", {7'b0, val0}, 8'h01);
    chk("w1_pc", pcs1, 8'hFE); chk("w1_ins", isai1, 8'hAB);
    cyc(1);
    chk("f2_pc", pcs0, 8'h01); chk("f2_ins", isai0, 8'h54);
    chk("w2_pc", pcs1, 8'hFF); chk("w2_ins", isai1, 8'hFF);
    cyc(1);
    chk("f3_pc", pcs0, 8'h02); chk("f3_ins", isai0, 8'h57);
    chk("w3_pc", pcs1, 8'h00); chk("w3_ins", isai1, 8'h55);

    // Decoder stalled from reset: queue fills and the PC holds.
    rst = 1'b1; cyc(1);
    rst = 1'b0; pronto = 1'b0; cyc(5);
    chk("stall_end", end0, 8'h02);
    chk("stall_head", pcs0, 8'h00);
    pronto = 1'b1;
    cyc(1); chk("drain1", pcs0, 8'h01);
    cyc(1); chk("drain2", pcs0, 8'h02);
    cyc(1); chk("drain3", pcs0, 8'h03);

    // Redirect with a full queue.
    pronto = 1'b0; cyc(3);
    desvio = 1'b1; alvo = 8'h80; cyc(1);
    desvio = 1'b0;
    chk("redir_val", {7'b0, val0}, 8'h00);
    chk("redir_end", end0, 8'h80);
    cyc(1);
    chk("redir_val2", {7'b0, val0}, 8'h01);
    chk("redir_pc", pcs0, 8'h80);
    chk("redir_ins", isai0, 8'hD5);

    // Reset beats a simultaneous redirect.
    cyc(2);
    rst = 1'b1; desvio = 1'b1; alvo = 8'h33; cyc(1);
    rst = 1'b0; desvio = 1'b0;
    chk("rstdes_val", {7'b0, val0}, 8'h00);
    chk("rstdes_end0", end0, 8'h00);
    chk("rstdes_end1", end1, 8'hFE);

    // Fetch disabled: queue drains, PC holds, then fetching resumes at the held PC.
    cyc(2);
    habilita = 1'b0; pronto = 1'b1; cyc(3);
    chk("hab_val", {7'b0, val0}, 8'h00);
    chk("hab_end", end0, 8'h02);
    habilita = 1'b1; cyc(1);
    chk("hab_res_pc", pcs0, 8'h02);
    chk("hab_res_val", {7'b0, val0}, 8'h01);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      habilita = ($urandom_range(0, 99) < 85);
      desvio   = ($urandom_range(0, 99) < 8);
      alvo     = 8'($urandom);
      pronto   = ($urandom_range(0, 99) < 70);
      cyc(1);
    end
    rst = 1'b0; desvio = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
